// File: rtl/axis_dest_crossbar_if.sv
// AXI-Stream bundle of N lanes packed side by side; lane i occupies [i*W +: W] of each field.
`timescale 1ns/1ps
interface axis_dest_crossbar_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned DATAW = 32,
   parameter int unsigned IDW   = 32,
   parameter int unsigned USERW = 32,
   parameter int unsigned DESTW = 6
);
   logic [N-1:0]       tvalid;
   logic [N-1:0]       tready;
   logic [N-1:0]       tlast;
   logic [N*DATAW-1:0] tdata;
   logic [N*IDW-1:0]   tid;
   logic [N*USERW-1:0] tuser;
   logic [N*DESTW-1:0] tdest;

   modport master (output tvalid, tlast, tdata, tid, tuser, tdest, input tready);
   modport slave  (input tvalid, tlast, tdata, tid, tuser, tdest, output tready);
endinterface

// File: rtl/axis_dest_crossbar.sv
// NUM_IN x NUM_OUT AXI-Stream crossbar routing whole packets by TDEST with per-output round-robin
// packet locking. Define AXIS_XBAR_OUT_REG_EN for a 2-entry skid buffer on every output.
`timescale 1ns/1ps
module axis_dest_crossbar #(
   parameter int unsigned NUM_IN  = 4,
   parameter int unsigned NUM_OUT = 4,
   parameter int unsigned DATAW   = 32,
   parameter int unsigned IDW     = 32,
   parameter int unsigned USERW   = 32,
   parameter int unsigned DESTW   = 6,
   parameter int unsigned INW     = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   axis_dest_crossbar_if.slave  s_axis,
   axis_dest_crossbar_if.master m_axis,
   output logic [15:0]          drop_cnt_o
);

   typedef enum logic {ST_IDLE, ST_LOCKED} out_state_e;

   typedef struct packed {
      logic             last;
      logic [DESTW-1:0] dest;
      logic [USERW-1:0] user;
      logic [IDW-1:0]   id;
      logic [DATAW-1:0] data;
   } beat_t;

   function automatic logic [INW-1:0] wrap_idx(input logic [INW-1:0] base, input int unsigned ofs);
      int unsigned s;
      s = (32'(base) + ofs) % NUM_IN;
      return s[INW-1:0];
   endfunction

   out_state_e         state_q [NUM_OUT];
   out_state_e         state_d [NUM_OUT];
   logic [INW-1:0]     owner_q [NUM_OUT];
   logic [INW-1:0]     owner_d [NUM_OUT];
   logic [INW-1:0]     ptr_q   [NUM_OUT];
   logic [INW-1:0]     ptr_d   [NUM_OUT];
   logic [NUM_IN-1:0]  drop_q, drop_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;

   beat_t              in_beat  [NUM_IN];
   logic [NUM_OUT-1:0] req      [NUM_IN];
   logic [NUM_IN-1:0]  in_locked, bad_dest, s_ready;
   logic [NUM_OUT-1:0] gnt, sel_valid, path_ready, fire, out_valid;
   logic [INW-1:0]     sel_idx  [NUM_OUT];
   beat_t              sel_beat [NUM_OUT];
   beat_t              out_beat [NUM_OUT];

   // NOTE: every variable gets a default before any condition, so no path can infer a latch.
   always_comb begin
      in_locked = '0;
      for (int j = 0; j < NUM_OUT; j++)
         if (state_q[j] == ST_LOCKED) in_locked[owner_q[j]] = 1'b1;
   end

   // Only a first beat (input neither locked nor draining) looks at TDEST.
   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         in_beat[i].last = s_axis.tlast[i];
         in_beat[i].dest = s_axis.tdest[i*DESTW +: DESTW];
         in_beat[i].user = s_axis.tuser[i*USERW +: USERW];
         in_beat[i].id   = s_axis.tid[i*IDW +: IDW];
         in_beat[i].data = s_axis.tdata[i*DATAW +: DATAW];
         bad_dest[i] = s_axis.tvalid[i] && !in_locked[i] && !drop_q[i] &&
                       (32'(in_beat[i].dest) >= NUM_OUT);
         for (int j = 0; j < NUM_OUT; j++)
            req[i][j] = s_axis.tvalid[i] && !in_locked[i] && !drop_q[i] &&
                        (32'(in_beat[i].dest) == 32'(j));
      end
   end

   // Descending scan so the requester closest to the pointer is the last, winning, write.
   always_comb begin
      for (int j = 0; j < NUM_OUT; j++) begin
         gnt[j]     = 1'b0;
         sel_idx[j] = '0;
         if (state_q[j] == ST_LOCKED) begin
            gnt[j]     = 1'b1;
            sel_idx[j] = owner_q[j];
         end else begin
            for (int k = NUM_IN - 1; k >= 0; k--) begin
               if (req[wrap_idx(ptr_q[j], k)][j]) begin
                  gnt[j]     = 1'b1;
                  sel_idx[j] = wrap_idx(ptr_q[j], k);
               end
            end
         end
         sel_valid[j] = gnt[j] && s_axis.tvalid[sel_idx[j]];
         sel_beat[j]  = in_beat[sel_idx[j]];
         fire[j]      = sel_valid[j] && path_ready[j];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) s_ready[i] = drop_q[i] || bad_dest[i];
      for (int j = 0; j < NUM_OUT; j++)
         if (gnt[j] && path_ready[j]) s_ready[sel_idx[j]] = 1'b1;
      if (!rst_n_i) s_ready = '0;
   end

   assign s_axis.tready = s_ready;

   always_comb begin
      for (int j = 0; j < NUM_OUT; j++) begin
         state_d[j] = state_q[j];
         owner_d[j] = owner_q[j];
         ptr_d[j]   = ptr_q[j];
         if (fire[j]) begin
            if (sel_beat[j].last) begin
               state_d[j] = ST_IDLE;
               ptr_d[j]   = wrap_idx(sel_idx[j], 1);
            end else if (state_q[j] == ST_IDLE) begin
               state_d[j] = ST_LOCKED;
               owner_d[j] = sel_idx[j];
            end
         end
      end
   end

   // Draining inputs are always ready; the 17-bit sum cannot wrap before saturation is applied.
   always_comb begin
      logic [16:0] drop_sum;
      drop_d   = drop_q;
      drop_sum = {1'b0, drop_cnt_q};
      for (int i = 0; i < NUM_IN; i++) begin
         if (s_axis.tvalid[i] && (drop_q[i] || bad_dest[i])) begin
            drop_d[i] = !s_axis.tlast[i];
            drop_sum  = drop_sum + 17'd1;
         end
      end
      drop_cnt_d = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int j = 0; j < NUM_OUT; j++) begin
            state_q[j] <= ST_IDLE;
            owner_q[j] <= '0;
            ptr_q[j]   <= '0;
         end
         drop_q     <= '0;
         drop_cnt_q <= '0;
      end else begin
         for (int j = 0; j < NUM_OUT; j++) begin
            state_q[j] <= state_d[j];
            owner_q[j] <= owner_d[j];
            ptr_q[j]   <= ptr_d[j];
         end
         drop_q     <= drop_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt_o = drop_cnt_q;

`ifdef AXIS_XBAR_OUT_REG_EN
   beat_t              buf_q [NUM_OUT][2];
   beat_t              buf_d [NUM_OUT][2];
   logic [NUM_OUT-1:0] wr_q, wr_d, rd_q, rd_d, pop;
   logic [1:0]         cnt_q [NUM_OUT];
   logic [1:0]         cnt_d [NUM_OUT];

   // Ready depends only on occupancy, which cuts the M_TREADY -> S_TREADY path.
   always_comb begin
      buf_d = buf_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      for (int j = 0; j < NUM_OUT; j++) begin
         path_ready[j] = (cnt_q[j] != 2'd2);
         out_valid[j]  = (cnt_q[j] != 2'd0);
         out_beat[j]   = buf_q[j][rd_q[j]];
         pop[j]        = out_valid[j] && m_axis.tready[j];
         if (fire[j]) begin
            buf_d[j][wr_q[j]] = sel_beat[j];
            wr_d[j]           = ~wr_q[j];
         end
         if (pop[j]) rd_d[j] = ~rd_q[j];
         cnt_d[j] = cnt_q[j] + 2'(fire[j]) - 2'(pop[j]);
      end
   end

   // NOTE: buffer storage is reset too, because the outputs must read zero straight out of reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int j = 0; j < NUM_OUT; j++) begin
            buf_q[j][0] <= '0;
            buf_q[j][1] <= '0;
            cnt_q[j]    <= '0;
         end
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
      end
   end
`else
   always_comb begin
      path_ready = m_axis.tready;
      out_valid  = rst_n_i ? sel_valid : '0;
      out_beat   = sel_beat;
   end
`endif

   always_comb begin
      for (int j = 0; j < NUM_OUT; j++) begin
         m_axis.tvalid[j]                  = out_valid[j];
         m_axis.tlast[j]                   = out_beat[j].last;
         m_axis.tdest[j*DESTW +: DESTW]    = out_beat[j].dest;
         m_axis.tuser[j*USERW +: USERW]    = out_beat[j].user;
         m_axis.tid[j*IDW +: IDW]          = out_beat[j].id;
         m_axis.tdata[j*DATAW +: DATAW]    = out_beat[j].data;
      end
   end

endmodule
